// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide unified memory port between
// instruction fetch and the load/store stage. Each access is split into
// little-endian byte transfers. Read data is assembled, extended and returned
// with a one-cycle done pulse. A stall request holds the pipeline while a
// requester waits.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic                  if_done,
   output logic [31:0]           if_inst,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [1:0]            ls_size,
   input  logic                  ls_signed,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [31:0]           ls_wdata,
   output logic                  ls_done,
   output logic [31:0]           ls_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wr,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din,
   output logic                  stallreq
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t      state;
   logic        is_fetch;
   logic        is_store;
   logic        is_signed;
   logic [1:0]  size_q;
   logic [2:0]  nbytes;
   logic [2:0]  cnt;
   logic [31:0] wshift;
   logic [31:0] rbuf;
   logic [31:0] next_rbuf;
   logic [31:0] ld_result;

   // Read bytes enter at the top of rbuf, so after n captures the access sits
   // in the top n bytes; extract and extend it according to the latched size.
   always_comb begin
      next_rbuf = {ram_din, rbuf[31:8]};
      ld_result = next_rbuf;
      case (size_q)
         2'd0:    ld_result = {{24{is_signed & next_rbuf[31]}}, next_rbuf[31:24]};
         2'd1:    ld_result = {{16{is_signed & next_rbuf[31]}}, next_rbuf[31:16]};
         default: ld_result = next_rbuf;
      endcase
   end

   // A requester is waiting unless its access is completing this very cycle.
   assign stallreq = ((if_req & ~if_flush) | ls_req) & ~(if_done | ls_done);

   // Arbitration and byte sequencing. cnt holds k during cycle T+k, where T is
   // the accepting cycle. Stores drive byte k-1 in cycle T+k; reads put
   // address k-1 out in cycle T+k and capture its byte one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         is_fetch  <= 1'b0;
         is_store  <= 1'b0;
         is_signed <= 1'b0;
         size_q    <= 2'd0;
         nbytes    <= 3'd0;
         cnt       <= 3'd0;
         wshift    <= 32'h0;
         rbuf      <= 32'h0;
         ram_addr  <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'h00;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         if_inst   <= 32'h0;
         ls_rdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if_done <= 1'b0;
               ls_done <= 1'b0;
               if (ls_req) begin
                  state     <= XFER;
                  is_fetch  <= 1'b0;
                  is_store  <= ls_we;
                  is_signed <= ls_signed;
                  size_q    <= ls_size;
                  case (ls_size)
                     2'd0:    nbytes <= 3'd1;
                     2'd1:    nbytes <= 3'd2;
                     default: nbytes <= 3'd4;
                  endcase
                  cnt      <= 3'd1;
                  ram_addr <= ls_addr;
                  ram_wr   <= ls_we;
                  ram_dout <= ls_wdata[7:0];
                  wshift   <= {8'h00, ls_wdata[31:8]};
               end else if (if_req && !if_flush) begin
                  state     <= XFER;
                  is_fetch  <= 1'b1;
                  is_store  <= 1'b0;
                  is_signed <= 1'b0;
                  size_q    <= 2'd2;
                  nbytes    <= 3'd4;
                  cnt       <= 3'd1;
                  ram_addr  <= if_addr;
                  ram_wr    <= 1'b0;
               end
            end

            XFER: begin
               if (is_fetch && if_flush) begin
                  state <= IDLE;
               end else if (is_store) begin
                  if (cnt == nbytes) begin
                     state   <= DONE;
                     ram_wr  <= 1'b0;
                     ls_done <= 1'b1;
                  end else begin
                     ram_addr <= ram_addr + ADDR_ONE;
                     ram_dout <= wshift[7:0];
                     wshift   <= wshift >> 8;
                     cnt      <= cnt + 3'd1;
                  end
               end else begin
                  if (cnt < nbytes) begin
                     ram_addr <= ram_addr + ADDR_ONE;
                  end
                  if (cnt >= 3'd2) begin
                     rbuf <= next_rbuf;
                  end
                  if (cnt == nbytes + 3'd1) begin
                     state <= DONE;
                     if (is_fetch) begin
                        if_done <= 1'b1;
                        if_inst <= next_rbuf;
                     end else begin
                        ls_done  <= 1'b1;
                        ls_rdata <= ld_result;
                     end
                  end
                  cnt <= cnt + 3'd1;
               end
            end

            DONE: begin
               if_done <= 1'b0;
               ls_done <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and randomized checks of mem_arbiter against
// a byte-array memory and a reference model of expected access results.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_done;
   logic [31:0] if_inst;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic        ls_signed;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        stallreq;

   logic        pl_we;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;

   logic [7:0]  ram_arr [0:65535];
   logic [7:0]  ref_mem [0:65535];

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          kind;
      int          size;
      bit          sgn;
      bit          flush;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [14];

   mem_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_inst(if_inst),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
      .stallreq(stallreq)
   );

   always #5 clk = ~clk;

   // Byte-wide memory: write strobe or preload port, read data one cycle late.
   always @(posedge clk) begin
      if (pl_we) ram_arr[pl_addr] <= pl_data;
      else if (ram_wr) ram_arr[ram_addr[15:0]] <= ram_dout;
      ram_din <= ram_arr[ram_addr[15:0]];
   end

   // Overall time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation exceeded its time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic preloadByte(input logic [15:0] a, input logic [7:0] d);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   function automatic int byteCount(input int kind, input int size);
      if (kind == 0) return 4;
      if (size == 0) return 1;
      if (size == 1) return 2;
      return 4;
   endfunction

   // Reference result: little-endian sum of n bytes, then two's-complement
   // reinterpretation of an n-byte value when signed.
   function automatic logic [31:0] refLoad(input logic [31:0] addr, input int n, input bit sgn);
      longint v = 0;
      longint span;
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr[15:0] + 16'(i);
         v = v + (longint'(ref_mem[a]) << (8 * i));
      end
      span = longint'(1) << (8 * n);
      if (sgn && n < 4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // Issue one access at the current cycle T and check every cycle up to done.
   task automatic applyStimulus(input int kind, input int size, input bit sgn, input bit flush_ls,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input string name);
      int n;
      int done_cyc;
      bit store;
      logic [31:0] exp_addr;
      logic [31:0] exp_byte;
      logic [15:0] a;
      n = byteCount(kind, size);
      store = (kind == 2);
      done_cyc = store ? n + 1 : n + 2;
      if (kind == 0) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         ls_req    = 1'b1;
         ls_we     = store;
         ls_size   = 2'(size);
         ls_signed = sgn;
         ls_addr   = addr;
         ls_wdata  = wdata;
         if_flush  = flush_ls;
      end
      #1 checkBit({name, "_stall_T"}, stallreq, 1'b1);
      for (int k = 1; k <= done_cyc; k++) begin
         @(negedge clk);
         if (k <= n) begin
            exp_addr = addr + 32'(k - 1);
            checkOutput({name, "_addr"}, ram_addr, exp_addr);
            checkBit({name, "_wr"}, ram_wr, store);
            if (store) begin
               exp_byte = (wdata >> (8 * (k - 1))) & 32'hFF;
               checkOutput({name, "_dout"}, {24'h0, ram_dout}, exp_byte);
            end
         end else begin
            checkBit({name, "_wr_idle"}, ram_wr, 1'b0);
         end
         checkBit({name, "_if_done"}, if_done, (kind == 0) && (k == done_cyc));
         checkBit({name, "_ls_done"}, ls_done, (kind != 0) && (k == done_cyc));
         checkBit({name, "_stall"}, stallreq, k != done_cyc);
      end
      if (kind == 0) checkOutput({name, "_inst"}, if_inst, exp);
      else if (!store) checkOutput({name, "_rdata"}, ls_rdata, exp);
      else begin
         for (int i = 0; i < n; i++) begin
            a = addr[15:0] + 16'(i);
            ref_mem[a] = 8'((wdata >> (8 * i)) & 32'hFF);
         end
      end
      if_req   = 1'b0;
      ls_req   = 1'b0;
      if_flush = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int kind;
      int size;
      bit sgn;
      bit fl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;

      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
      ls_addr = 32'h0; ls_wdata = 32'h0;
      pl_we = 1'b0; pl_addr = 16'h0; pl_data = 8'h0;

      vecs[0]  = '{0, 2, 1'b0, 1'b0, 32'h0000_0100, 32'h0,          32'h0010_0513, "fetch_100"};
      vecs[1]  = '{2, 2, 1'b0, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF,  32'h0,         "store_word"};
      vecs[2]  = '{1, 2, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          32'hDEAD_BEEF, "load_word"};
      vecs[3]  = '{2, 0, 1'b0, 1'b0, 32'h0000_0021, 32'h0000_0080,  32'h0,         "store_byte"};
      vecs[4]  = '{1, 0, 1'b1, 1'b0, 32'h0000_0021, 32'h0,          32'hFFFF_FF80, "load_byte_s"};
      vecs[5]  = '{1, 0, 1'b0, 1'b0, 32'h0000_0021, 32'h0,          32'h0000_0080, "load_byte_u"};
      vecs[6]  = '{2, 1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_8001,  32'h0,         "store_half"};
      vecs[7]  = '{1, 1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h0000_8001, "load_half_u"};
      vecs[8]  = '{1, 1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'hFFFF_8001, "load_half_s"};
      vecs[9]  = '{2, 3, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h1122_3344,  32'h0,         "store_wrap"};
      vecs[10] = '{1, 2, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0,          32'h1122_3344, "load_wrap"};
      vecs[11] = '{1, 2, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          32'hDEAD_80EF, "load_word2"};
      vecs[12] = '{1, 0, 1'b1, 1'b0, 32'h0000_0023, 32'h0,          32'hFFFF_FFDE, "load_byte_hi"};
      vecs[13] = '{1, 1, 1'b1, 1'b0, 32'h0000_0022, 32'h0,          32'hFFFF_DEAD, "load_half_hi"};

      repeat (2) @(negedge clk);
      checkBit("rst_ram_wr", ram_wr, 1'b0);
      checkOutput("rst_ram_addr", ram_addr, 32'h0);
      checkOutput("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
      checkBit("rst_if_done", if_done, 1'b0);
      checkBit("rst_ls_done", ls_done, 1'b0);
      checkOutput("rst_if_inst", if_inst, 32'h0);
      checkOutput("rst_ls_rdata", ls_rdata, 32'h0);

      preloadByte(16'h0100, 8'h13); preloadByte(16'h0101, 8'h05);
      preloadByte(16'h0102, 8'h10); preloadByte(16'h0103, 8'h00);
      preloadByte(16'h0200, 8'h93); preloadByte(16'h0201, 8'h00);
      preloadByte(16'h0202, 8'h10); preloadByte(16'h0203, 8'h00);
      for (int i = 0; i < 256; i++) preloadByte(16'h1000 + 16'(i), 8'($urandom));

      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++)
         applyStimulus(vecs[i].kind, vecs[i].size, vecs[i].sgn, vecs[i].flush,
                       vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);

      // Contention: load byte and fetch requested together.
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0; ls_addr = 32'h21;
      if_req = 1'b1; if_addr = 32'h100;
      #1 checkBit("cont_stall_T", stallreq, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) checkOutput("cont_ls_first", ram_addr, 32'h21);
         if (c == 5) checkOutput("cont_fetch_addr", ram_addr, 32'h100);
         checkBit("cont_ls_done", ls_done, c == 3);
         checkBit("cont_if_done", if_done, c == 10);
         checkBit("cont_stall", stallreq, !(c == 3 || c == 10));
         if (c == 3) begin
            checkOutput("cont_rdata", ls_rdata, 32'h80);
            ls_req = 1'b0;
         end
      end
      checkOutput("cont_inst", if_inst, 32'h0010_0513);
      if_req = 1'b0;
      @(negedge clk);

      // Flush of an in-flight fetch, then a clean fetch elsewhere.
      if_req = 1'b1; if_addr = 32'h100;
      @(negedge clk);
      checkOutput("flush_addr0", ram_addr, 32'h100);
      @(negedge clk);
      checkOutput("flush_addr1", ram_addr, 32'h101);
      if_flush = 1'b1;
      #1 checkBit("flush_stall", stallreq, 1'b0);
      @(negedge clk);
      if_flush = 1'b0;
      if_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         checkBit("flush_no_done", if_done, 1'b0);
         checkOutput("flush_addr_hold", ram_addr, 32'h101);
         @(negedge clk);
      end
      applyStimulus(0, 2, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0010_0093, "fetch_200");

      // Randomized accesses against the reference model.
      for (int r = 0; r < 40; r++) begin
         kind = $urandom_range(0, 2);
         size = $urandom_range(0, 3);
         sgn  = 1'($urandom_range(0, 1));
         fl   = (kind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (kind == 0) addr = 32'h1000 + 32'(4 * $urandom_range(0, 63));
         else addr = 32'h1000 + 32'($urandom_range(0, 252));
         wdata = $urandom;
         exp = (kind == 2) ? 32'h0 : refLoad(addr, byteCount(kind, size), (kind == 1) && sgn);
         applyStimulus(kind, size, sgn, fl, addr, wdata, exp, "rand");
      end

      // Reset in the middle of a store.
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      checkBit("rstx_wr_on", ram_wr, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      ls_req = 1'b0;
      @(negedge clk);
      checkBit("rstx_ram_wr", ram_wr, 1'b0);
      checkOutput("rstx_ram_addr", ram_addr, 32'h0);
      checkOutput("rstx_ram_dout", {24'h0, ram_dout}, 32'h0);
      checkBit("rstx_ls_done", ls_done, 1'b0);
      checkOutput("rstx_if_inst", if_inst, 32'h0);
      checkOutput("rstx_ls_rdata", ls_rdata, 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkBit("rstx_no_done", ls_done, 1'b0);
         checkBit("rstx_no_wr", ram_wr, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
